// File: rtl/bn_param_pkg.sv
// rtl/bn_param_pkg.sv - field encoding and per-channel record shared by the BN parameter bank
package bn_param_pkg;

  localparam int NUM_FIELD = 6;
  localparam int BN_DW     = 16;

  typedef enum logic [2:0] {
    FIELD_STAN_DEV = 3'd0,
    FIELD_AVG      = 3'd1,
    FIELD_GAMMA    = 3'd2,
    FIELD_BETA     = 3'd3,
    FIELD_A        = 3'd4,
    FIELD_B        = 3'd5
  } field_e;

  typedef struct packed {
    logic [BN_DW-1:0] stan_dev;
    logic [BN_DW-1:0] avg;
    logic [BN_DW-1:0] gamma;
    logic [BN_DW-1:0] beta;
    logic [BN_DW-1:0] a;
    logic [BN_DW-1:0] b;
  } bn_ch_t;

endpackage

// File: rtl/bn_param_bank_mem.sv
// rtl/bn_param_bank_mem.sv - one bank of NUM_CH x NUM_FIELD parameter registers
// Field-granular write, channel-wide zero, channel-wide combinational read.
module bn_param_bank_mem
  import bn_param_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int W      = 16,
  parameter int AW     = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         wr_ch_i,
  input  logic [2:0]            wr_field_i,
  input  logic [W-1:0]          wr_data_i,
  input  logic                  zero_i,
  input  logic [AW-1:0]         zero_ch_i,
  input  logic [AW-1:0]         rd_ch_i,
  output logic [NUM_FIELD*W-1:0] rd_data_o
);

  logic [W-1:0] mem_q [NUM_CH][NUM_FIELD];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int f = 0; f < NUM_FIELD; f++)
          mem_q[c][f] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        for (int f = 0; f < NUM_FIELD; f++)
          if (zero_i && zero_ch_i == AW'(c))
            mem_q[c][f] <= '0;
          else if (we_i && wr_ch_i == AW'(c) && wr_field_i == 3'(f))
            mem_q[c][f] <= wr_data_i;
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (rd_ch_i == AW'(c))
        for (int f = 0; f < NUM_FIELD; f++)
          rd_data_o[f*W +: W] = mem_q[c][f];
  end

endmodule

// File: rtl/bn_param_bank.sv
// rtl/bn_param_bank.sv - double-buffered multi-channel BN parameter bank with sequenced shadow clear
// Optional BN_PARAM_PARITY_EN adds per-field even parity and the rd_par_err_o output.
module bn_param_bank
  import bn_param_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 8,
  parameter int CH_WIDTH   = $clog2(NUM_CH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [CH_WIDTH-1:0]   wr_ch_i,
  input  logic [2:0]            wr_field_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  commit_i,
  input  logic                  clr_shadow_i,
  input  logic                  rd_req_i,
  input  logic [CH_WIDTH-1:0]   rd_ch_i,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] stan_dev_o,
  output logic [DATA_WIDTH-1:0] avg_o,
  output logic [DATA_WIDTH-1:0] gamma_o,
  output logic [DATA_WIDTH-1:0] beta_o,
  output logic [DATA_WIDTH-1:0] a_o,
  output logic [DATA_WIDTH-1:0] b_o,
`ifdef BN_PARAM_PARITY_EN
  output logic                  rd_par_err_o,
`endif
  output logic                  bank_sel_o,
  output logic                  shadow_full_o,
  output logic                  busy_o,
  output logic                  err_addr_o,
  output logic                  err_partial_o
);

  localparam int AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
`ifdef BN_PARAM_PARITY_EN
  localparam int SW = DATA_WIDTH + 1;
`else
  localparam int SW = DATA_WIDTH;
`endif

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  state_e                      state_q;
  logic [AW-1:0]               clr_cnt_q;
  logic                        pend_q, busy_q, bank_sel_q, err_addr_q, err_partial_q, rd_valid_q;
  logic [NUM_CH*NUM_FIELD-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0]       fld_q [NUM_FIELD];
  logic [DATA_WIDTH-1:0]       fld_d [NUM_FIELD];
`ifdef BN_PARAM_PARITY_EN
  logic                        par_err_q, par_err_d;
`endif

  logic                        in_clr, wr_fire, wr_legal, rd_ok, clr_last, do_swap, start_clr;
  logic [SW-1:0]               store_data;
  logic [NUM_FIELD*SW-1:0]     rd_bank0, rd_bank1, rd_act;

  assign in_clr     = (state_q == ST_CLEAR);
  assign wr_fire    = wr_valid_i & ~in_clr;
  assign wr_legal   = (32'(wr_ch_i) < NUM_CH) && (wr_field_i <= FIELD_B);
  assign rd_ok      = (32'(rd_ch_i) < NUM_CH);
  assign clr_last   = in_clr && (clr_cnt_q == AW'(NUM_CH - 1));
  // A commit seen during the clear is deferred to the edge that ends it.
  assign do_swap    = in_clr ? (clr_last && (pend_q || commit_i)) : commit_i;
  assign start_clr  = ~in_clr & clr_shadow_i;
`ifdef BN_PARAM_PARITY_EN
  assign store_data = {^wr_data_i, wr_data_i};
`else
  assign store_data = wr_data_i;
`endif

  bn_param_bank_mem #(.NUM_CH(NUM_CH), .W(SW), .AW(AW)) u_bank0 (
    .clk_i(clk_i), .rst_i(rst_i),
    .we_i(wr_fire & wr_legal & bank_sel_q), .wr_ch_i(wr_ch_i[AW-1:0]),
    .wr_field_i(wr_field_i), .wr_data_i(store_data),
    .zero_i(in_clr & bank_sel_q), .zero_ch_i(clr_cnt_q),
    .rd_ch_i(rd_ch_i[AW-1:0]), .rd_data_o(rd_bank0)
  );

  bn_param_bank_mem #(.NUM_CH(NUM_CH), .W(SW), .AW(AW)) u_bank1 (
    .clk_i(clk_i), .rst_i(rst_i),
    .we_i(wr_fire & wr_legal & ~bank_sel_q), .wr_ch_i(wr_ch_i[AW-1:0]),
    .wr_field_i(wr_field_i), .wr_data_i(store_data),
    .zero_i(in_clr & ~bank_sel_q), .zero_ch_i(clr_cnt_q),
    .rd_ch_i(rd_ch_i[AW-1:0]), .rd_data_o(rd_bank1)
  );

  assign rd_act = bank_sel_q ? rd_bank1 : rd_bank0;

  always_comb begin
    mask_d = mask_q;
    for (int c = 0; c < NUM_CH; c++)
      for (int f = 0; f < NUM_FIELD; f++)
        if (wr_fire && wr_legal && wr_ch_i == CH_WIDTH'(c) && wr_field_i == 3'(f))
          mask_d[c*NUM_FIELD+f] = 1'b1;
    if (do_swap || start_clr) mask_d = '0;
  end

  always_comb begin
    for (int f = 0; f < NUM_FIELD; f++) fld_d[f] = fld_q[f];
`ifdef BN_PARAM_PARITY_EN
    par_err_d = 1'b0;
`endif
    if (rd_req_i) begin
      for (int f = 0; f < NUM_FIELD; f++) begin
        fld_d[f] = rd_ok ? rd_act[f*SW +: DATA_WIDTH] : '0;
`ifdef BN_PARAM_PARITY_EN
        if (rd_ok && ^rd_act[f*SW +: SW]) par_err_d = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      clr_cnt_q     <= '0;
      pend_q        <= 1'b0;
      busy_q        <= 1'b0;
      bank_sel_q    <= 1'b0;
      err_addr_q    <= 1'b0;
      err_partial_q <= 1'b0;
      rd_valid_q    <= 1'b0;
      mask_q        <= '0;
      for (int f = 0; f < NUM_FIELD; f++) fld_q[f] <= '0;
`ifdef BN_PARAM_PARITY_EN
      par_err_q     <= 1'b0;
`endif
    end else begin
      mask_q     <= mask_d;
      rd_valid_q <= rd_req_i;
      for (int f = 0; f < NUM_FIELD; f++) fld_q[f] <= fld_d[f];
`ifdef BN_PARAM_PARITY_EN
      par_err_q  <= par_err_d;
`endif
      if (wr_fire && !wr_legal) err_addr_q <= 1'b1;
      if (do_swap) begin
        bank_sel_q <= ~bank_sel_q;
        pend_q     <= 1'b0;
        if (!shadow_full_o) err_partial_q <= 1'b1;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (clr_shadow_i) begin
            state_q   <= ST_CLEAR;
            busy_q    <= 1'b1;
            clr_cnt_q <= '0;
          end
        end
        ST_CLEAR: begin
          if (commit_i && !clr_last) pend_q <= 1'b1;
          if (clr_last) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q + AW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wr_ready_o    = ~busy_q;
  assign busy_o        = busy_q;
  assign bank_sel_o    = bank_sel_q;
  assign shadow_full_o = &mask_q;
  assign err_addr_o    = err_addr_q;
  assign err_partial_o = err_partial_q;
  assign rd_valid_o    = rd_valid_q;
  assign stan_dev_o    = fld_q[FIELD_STAN_DEV];
  assign avg_o         = fld_q[FIELD_AVG];
  assign gamma_o       = fld_q[FIELD_GAMMA];
  assign beta_o        = fld_q[FIELD_BETA];
  assign a_o           = fld_q[FIELD_A];
  assign b_o           = fld_q[FIELD_B];
`ifdef BN_PARAM_PARITY_EN
  assign rd_par_err_o  = par_err_q;
`endif

endmodule

// File: tb/tb_bn_param_bank.sv
// tb/tb_bn_param_bank.sv - self-checking bench for bn_param_bank against a behavioural bank model
module tb_bn_param_bank;
  import bn_param_pkg::*;

  localparam int NCH = 4;
  localparam int CW  = 3;
  localparam int DW  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid, wr_ready, commit, clr_shadow, rd_req, rd_valid;
  logic [CW-1:0] wr_ch, rd_ch;
  logic [2:0]    wr_field;
  logic [DW-1:0] wr_data, stan_dev, avg, gamma, beta, a, b;
  logic          bank_sel, shadow_full, busy, err_addr, err_partial;
`ifdef BN_PARAM_PARITY_EN
  logic          rd_par_err;
`endif

  bn_param_bank #(.DATA_WIDTH(DW), .NUM_CH(NCH), .CH_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_ch_i(wr_ch),
    .wr_field_i(wr_field), .wr_data_i(wr_data),
    .commit_i(commit), .clr_shadow_i(clr_shadow),
    .rd_req_i(rd_req), .rd_ch_i(rd_ch), .rd_valid_o(rd_valid),
    .stan_dev_o(stan_dev), .avg_o(avg), .gamma_o(gamma),
    .beta_o(beta), .a_o(a), .b_o(b),
`ifdef BN_PARAM_PARITY_EN
    .rd_par_err_o(rd_par_err),
`endif
    .bank_sel_o(bank_sel), .shadow_full_o(shadow_full), .busy_o(busy),
    .err_addr_o(err_addr), .err_partial_o(err_partial)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model: two plain banks, a loaded flag per field, and a count of channels left to clear.
  logic [DW-1:0] m_bank [2][NCH][NUM_FIELD];
  bit            m_mask [NCH][NUM_FIELD];
  logic [DW-1:0] m_fld  [NUM_FIELD];
  bit            m_sel, m_pend, m_eaddr, m_epart, m_rdv;
  int            m_clr_left;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit model_full();
    for (int c = 0; c < NCH; c++)
      for (int f = 0; f < NUM_FIELD; f++)
        if (!m_mask[c][f]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bn_ch_t snap();
    bn_ch_t s;
    s.stan_dev = stan_dev; s.avg = avg; s.gamma = gamma;
    s.beta = beta; s.a = a; s.b = b;
    return s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < NCH; c++)
        for (int f = 0; f < NUM_FIELD; f++) m_bank[k][c][f] = '0;
    for (int c = 0; c < NCH; c++)
      for (int f = 0; f < NUM_FIELD; f++) m_mask[c][f] = 1'b0;
    for (int f = 0; f < NUM_FIELD; f++) m_fld[f] = '0;
    m_sel = 0; m_pend = 0; m_eaddr = 0; m_epart = 0; m_rdv = 0; m_clr_left = 0;
  endtask

  task automatic model_step();
    int sh      = m_sel ? 0 : 1;
    bit busy_now = (m_clr_left > 0);
    bit full_now = model_full();
    bit swap     = 1'b0;
    m_rdv = rd_req;
    if (rd_req) begin
      for (int f = 0; f < NUM_FIELD; f++) begin
        if (rd_ch < NCH) m_fld[f] = m_bank[m_sel][rd_ch][f];
        else             m_fld[f] = '0;
      end
    end
    if (wr_valid && !busy_now) begin
      if (wr_ch < NCH && wr_field < NUM_FIELD) begin
        m_bank[sh][wr_ch][wr_field] = wr_data;
        m_mask[wr_ch][wr_field] = 1'b1;
      end else begin
        m_eaddr = 1'b1;
      end
    end
    if (busy_now) begin
      for (int f = 0; f < NUM_FIELD; f++) m_bank[sh][NCH-m_clr_left][f] = '0;
      if (commit) m_pend = 1'b1;
      m_clr_left--;
      if (m_clr_left == 0 && m_pend) swap = 1'b1;
    end else begin
      swap = commit;
      if (clr_shadow) begin
        m_clr_left = NCH;
        for (int c = 0; c < NCH; c++)
          for (int f = 0; f < NUM_FIELD; f++) m_mask[c][f] = 1'b0;
      end
    end
    if (swap) begin
      if (!full_now) m_epart = 1'b1;
      m_sel  = ~m_sel;
      m_pend = 1'b0;
      for (int c = 0; c < NCH; c++)
        for (int f = 0; f < NUM_FIELD; f++) m_mask[c][f] = 1'b0;
    end
  endtask

  task automatic check_outputs();
    chk("rd_valid", rd_valid, m_rdv);
    chk("stan_dev", stan_dev, m_fld[0]);
    chk("avg", avg, m_fld[1]);
    chk("gamma", gamma, m_fld[2]);
    chk("beta", beta, m_fld[3]);
    chk("a", a, m_fld[4]);
    chk("b", b, m_fld[5]);
    chk("bank_sel", bank_sel, m_sel);
    chk("shadow_full", shadow_full, model_full());
    chk("busy", busy, (m_clr_left > 0));
    chk("err_addr", err_addr, m_eaddr);
    chk("err_partial", err_partial, m_epart);
`ifdef BN_PARAM_PARITY_EN
    chk("rd_par_err", rd_par_err, 1'b0);
`endif
  endtask

  task automatic idle();
    wr_valid = 0; wr_ch = '0; wr_field = '0; wr_data = '0;
    commit = 0; clr_shadow = 0; rd_req = 0; rd_ch = '0;
  endtask

  // Called at a negedge with inputs already driven; returns at the following negedge.
  task automatic tick();
    chk("wr_ready", wr_ready, (m_clr_left == 0));
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic check_reset_literals(input string tag);
    chk({tag, "_bank_sel"}, bank_sel, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_rd_valid"}, rd_valid, 1'b0);
    chk({tag, "_shadow_full"}, shadow_full, 1'b0);
    chk({tag, "_err"}, {err_addr, err_partial}, 2'b00);
    chk({tag, "_fields"}, stan_dev | avg | gamma | beta | a | b, 16'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check_reset_literals("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  bn_ch_t got;
  int     busy_cnt;
  bit     seen_idle;
  logic [DW-1:0] acc;

  initial begin
    idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // Same-cycle write + commit + read from reset.
    idle(); wr_valid = 1; wr_ch = 0; wr_field = FIELD_GAMMA; wr_data = 16'hBEEF;
    commit = 1; rd_req = 1; rd_ch = 0;
    tick();
    chk("swap_read_old_gamma", gamma, 16'h0000);
    chk("swap_bank_sel", bank_sel, 1'b1);
    chk("swap_err_partial", err_partial, 1'b1);
    idle(); rd_req = 1; rd_ch = 0;
    tick();
    chk("swap_read_new_gamma", gamma, 16'hBEEF);
    idle();
    tick();
    chk("rd_valid_single_pulse", rd_valid, 1'b0);
    chk("field_hold", gamma, 16'hBEEF);

    do_reset();

    // Fill all 24 fields, commit, read channel 2.
    for (int c = 0; c < NCH; c++)
      for (int f = 0; f < NUM_FIELD; f++) begin
        idle(); wr_valid = 1; wr_ch = CW'(c); wr_field = 3'(f);
        wr_data = 16'h0100 + 16'(c * 16 + f);
        tick();
      end
    chk("fill_shadow_full", shadow_full, 1'b1);
    idle(); commit = 1;
    tick();
    chk("fill_shadow_full_cleared", shadow_full, 1'b0);
    chk("fill_bank_sel", bank_sel, 1'b1);
    chk("fill_no_partial", err_partial, 1'b0);
    chk("fill_rd_valid_idle", rd_valid, 1'b0);
    idle(); rd_req = 1; rd_ch = 2;
    tick();
    got = snap();
    chk("fill_rd_valid", rd_valid, 1'b1);
    chk("fill_ch2_avg", got.avg, 16'h0121);
    chk("fill_ch2_b", got.b, 16'h0125);
    idle(); wr_valid = 1; wr_ch = 3; wr_field = FIELD_A; wr_data = 16'h7777;
    tick();

    // Clear followed one cycle later by commit.
    idle(); clr_shadow = 1;
    tick();
    chk("clr_busy_start", busy, 1'b1);
    busy_cnt = 1;
    seen_idle = 0;
    idle(); commit = 1;
    chk("clr_wr_ready_low", wr_ready, 1'b0);
    tick();
    if (busy) busy_cnt++;
    for (int i = 0; i < 8; i++) begin
      idle(); wr_valid = 1; wr_ch = CW'(i % NCH); wr_field = FIELD_AVG; wr_data = 16'hA5A5;
      if (busy) chk("clr_wr_ready", wr_ready, 1'b0);
      tick();
      if (busy) begin
        busy_cnt++;
        chk("clr_sel_hold", bank_sel, 1'b1);
      end else if (!seen_idle) begin
        seen_idle = 1;
        chk("clr_swap_on_idle", bank_sel, 1'b0);
      end
    end
    chk("clr_busy_cycles", busy_cnt, 4);
    acc = '0;
    for (int c = 0; c < NCH; c++) begin
      idle(); rd_req = 1; rd_ch = CW'(c);
      tick();
      acc = acc | stan_dev | avg | gamma | beta | a | b;
    end
    chk("clr_active_zero", acc, 16'h0);

    // Illegal write address and out-of-range read.
    idle(); wr_valid = 1; wr_ch = 5; wr_field = FIELD_GAMMA; wr_data = 16'h1234;
    chk("illegal_wr_ready", wr_ready, 1'b1);
    tick();
    chk("illegal_err_addr", err_addr, 1'b1);
    idle(); rd_req = 1; rd_ch = 7;
    tick();
    chk("oor_rd_valid", rd_valid, 1'b1);
    chk("oor_fields", stan_dev | avg | gamma | beta | a | b, 16'h0);

    // Reset two cycles into a clear with a commit pending.
    idle(); commit = 1;
    tick();
    idle(); clr_shadow = 1;
    tick();
    idle(); commit = 1;
    tick();
    idle();
    tick();
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #2;
    model_reset();
    check_reset_literals("midclr_reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idle();
      tick();
    end
    chk("post_rst_no_swap", bank_sel, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      idle();
      wr_valid   = ($urandom_range(0, 1) == 1);
      wr_ch      = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(4, 7)) : CW'($urandom_range(0, 3));
      wr_field   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      wr_data    = 16'($urandom);
      commit     = ($urandom_range(0, 15) == 0);
      clr_shadow = ($urandom_range(0, 39) == 0);
      rd_req     = ($urandom_range(0, 1) == 1);
      rd_ch      = ($urandom_range(0, 7) == 0) ? CW'($urandom_range(4, 7)) : CW'($urandom_range(0, 3));
      tick();
    end

`ifdef BN_PARAM_PARITY_EN
    begin
      logic [DW:0] pv;
      idle();
      if (bank_sel) begin
        pv = dut.u_bank1.mem_q[1][3];
        force dut.u_bank1.mem_q[1][3] = pv ^ 17'h1;
      end else begin
        pv = dut.u_bank0.mem_q[1][3];
        force dut.u_bank0.mem_q[1][3] = pv ^ 17'h1;
      end
      rd_req = 1; rd_ch = 1;
      @(posedge clk); #1;
      chk("par_err_ch1", rd_par_err, 1'b1);
      @(negedge clk);
      rd_ch = 0;
      @(posedge clk); #1;
      chk("par_ok_ch0", rd_par_err, 1'b0);
      @(negedge clk);
      idle();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
